// File: rtl/l09_counter_ctrl.sv
// Two-requester round-robin front end for l08_counter.
// Grants the counter to one requester at a time, pulses up for the sampled burst
// length, then reports completion together with the final counter value.
module l09_counter_ctrl #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic [1:0]       req_i,
    input  logic [LEN_W-1:0] len0_i,
    input  logic [LEN_W-1:0] len1_i,
    input  logic [1:0]       counter_3_i,
    output logic             up_o,
    output logic [1:0]       gnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic             done_abort_o,
    output logic [1:0]       done_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q;
    logic               id_q;
    logic               last_q;
    logic               abort_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [1:0]         gnt_q;
    logic               busy_q;
    logic               done_q;

    logic               grant_id;
    logic [LEN_W-1:0]   grant_len;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_id = 1'b0;
        unique case (req_i)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_q;
            default: grant_id = 1'b0;
        endcase
        grant_len = grant_id ? len1_i : len0_i;
    end

    // Controller FSM with registered grant/busy/done and burst bookkeeping.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q     <= StIdle;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            abort_q     <= 1'b0;
            remaining_q <= '0;
            gnt_q       <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (|req_i) begin
                        gnt_q       <= grant_id ? 2'b10 : 2'b01;
                        busy_q      <= 1'b1;
                        id_q        <= grant_id;
                        last_q      <= grant_id;
                        remaining_q <= grant_len;
                        abort_q     <= 1'b0;
                        if (grant_len != '0) begin
                            state_q <= StRun;
                        end else begin
                            // Zero-length burst completes without any up cycle.
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!req_i[id_q]) begin
                        // Requester withdrew: keep what was issued, report abort.
                        state_q <= StDone;
                        abort_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    abort_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    gnt_q   <= 2'b00;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // up follows req combinationally so a dropped request stops counting at once.
    always_comb begin
        up_o         = (state_q == StRun) & req_i[id_q];
        gnt_o        = gnt_q;
        busy_o       = busy_q;
        done_o       = done_q;
        done_id_o    = done_q & id_q;
        done_abort_o = done_q & abort_q;
        done_cnt_o   = done_q ? counter_3_i : 2'b00;
    end

endmodule

// File: tb/tb_l09_counter_ctrl.sv
// Directed bench for l09_counter_ctrl with a mod-3 counter model and a done scoreboard.
module tb_l09_counter_ctrl;

    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             n_rst;
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [1:0]       cnt_q;
    logic             up;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             done_abort;
    logic [1:0]       done_cnt;

    typedef struct {
        logic       id;
        logic       abort;
        logic [1:0] cnt;
        int         ups;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_c    = 0;
    int   up_seen  = 0;

    l09_counter_ctrl #(.LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .n_rst_i      (n_rst),
        .req_i        (req),
        .len0_i       (len0),
        .len1_i       (len1),
        .counter_3_i  (cnt_q),
        .up_o         (up),
        .gnt_o        (gnt),
        .busy_o       (busy),
        .done_o       (done),
        .done_id_o    (done_id),
        .done_abort_o (done_abort),
        .done_cnt_o   (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mod-3 counter standing in for l08_counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)  cnt_q <= 2'd0;
        else if (up) cnt_q <= (cnt_q == 2'd2) ? 2'd0 : cnt_q + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic id, input logic ab, input int ups);
        exp_t e;
        exp_c   = (exp_c + ups) % 3;
        e.id    = id;
        e.abort = ab;
        e.cnt   = 2'(exp_c);
        e.ups   = ups;
        sb.push_back(e);
    endtask

    // Returns the number of falling edges until done is seen (0 on timeout).
    task automatic wait_done(input string tag, input int max, output int n);
        n = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle invariants, up counting and scoreboard comparison on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                up_seen = 0;
            end else begin
                if (up) up_seen++;
                if (!busy) begin
                    chk("idle_gnt", 32'(gnt), 32'd0);
                    chk("idle_up", 32'(up), 32'd0);
                end
                if (!done) begin
                    chk("cnt_when_not_done", 32'(done_cnt), 32'd0);
                end else if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("done_abort", 32'(done_abort), 32'(e.abort));
                    chk("done_cnt", 32'(done_cnt), 32'(e.cnt));
                    chk("up_cycles", 32'(up_seen), 32'(e.ups));
                    chk("gnt_in_done", 32'(gnt), e.id ? 32'd2 : 32'd1);
                    up_seen = 0;
                end
            end
        end
    end

    initial begin
        int n;
        n_rst = 1'b0;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_up", 32'(up), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_done_abort", 32'(done_abort), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        step();
        n_rst = 1'b1;
        exp_c = 0;
        step();

        // Basic burst: 4 up cycles from counter 0 ends at 1.
        req  = 2'b01;
        len0 = 4'd4;
        push(1'b0, 1'b0, 4);
        @(negedge clk);
        chk("t1_gnt_idle", 32'(gnt), 32'd0);
        wait_done("t1", 20, n);
        chk("t1_latency", 32'(n), 32'd5);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("t1_gnt_after", 32'(gnt), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        step();

        // Zero-length burst for requester 1.
        req  = 2'b10;
        len1 = 4'd0;
        push(1'b1, 1'b0, 0);
        wait_done("t3", 10, n);
        chk("t3_latency", 32'(n), 32'd2);
        chk("t3_gnt", 32'(gnt), 32'd2);
        step();
        req = 2'b00;
        @(negedge clk);
        chk("t3_busy_after", 32'(busy), 32'd0);
        step();

        // Contention: grants alternate 0,1,0,1 with one idle cycle between bursts.
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd3;
        push(1'b0, 1'b0, 2);
        push(1'b1, 1'b0, 3);
        push(1'b0, 1'b0, 2);
        push(1'b1, 1'b0, 3);
        wait_done("t2a", 20, n);
        chk("t2a_latency", 32'(n), 32'd4);
        wait_done("t2b", 20, n);
        chk("t2b_gap", 32'(n), 32'd5);
        wait_done("t2c", 20, n);
        chk("t2c_gap", 32'(n), 32'd4);
        wait_done("t2d", 20, n);
        chk("t2d_gap", 32'(n), 32'd5);
        step();
        req = 2'b00;
        step();

        // Abort after two up cycles.
        req  = 2'b01;
        len0 = 4'd5;
        push(1'b0, 1'b1, 2);
        step();
        step();
        step();
        req = 2'b00;
        @(negedge clk);
        chk("t4_up_dropped", 32'(up), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        wait_done("t4", 10, n);
        chk("t4_done_next", 32'(n), 32'd1);
        step();
        step();

        // Reset in the middle of a burst: no done, outputs clear at once.
        req  = 2'b01;
        len0 = 4'd5;
        step();
        step();
        step();
        n_rst = 1'b0;
        #1;
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_up", 32'(up), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        req  = 2'b11;
        len0 = 4'd1;
        len1 = 4'd1;
        step();
        n_rst = 1'b1;
        exp_c = 0;
        push(1'b0, 1'b0, 1);
        push(1'b1, 1'b0, 1);
        wait_done("t5a", 10, n);
        chk("t5a_latency", 32'(n), 32'd3);
        wait_done("t5b", 10, n);
        chk("t5b_gap", 32'(n), 32'd3);
        step();
        req = 2'b00;
        step();

        // Max length, len changed mid-burst must not matter.
        req  = 2'b01;
        len0 = 4'd15;
        push(1'b0, 1'b0, 15);
        step();
        step();
        step();
        len0 = 4'd1;
        wait_done("t6", 40, n);
        chk("t6_latency", 32'(n), 32'd14);
        step();
        req = 2'b00;
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
